// File: rtl/rptr_sync_w.sv
// Write-domain receiver for the gray read pointer: synchronizer chain, gray-to-binary
// decode, writer-side occupancy/almost_full and a sticky error flag.
module rptr_sync_w #(
  parameter int PTR_WIDTH   = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 6
) (
  input  logic                 clk_w,
  input  logic                 arst,
  input  logic [PTR_WIDTH:0]   g_rptr,
  input  logic [PTR_WIDTH:0]   b_wptr,
  input  logic                 clr_err,
  output logic [PTR_WIDTH:0]   g_rptr_sync,
  output logic [PTR_WIDTH:0]   b_rptr_sync,
  output logic [PTR_WIDTH:0]   w_level,
  output logic                 almost_full,
  output logic                 gray_err
);

  localparam logic [PTR_WIDTH:0] DEPTH  = {1'b1, {PTR_WIDTH{1'b0}}};
  localparam logic [PTR_WIDTH:0] AF_LVL = (PTR_WIDTH + 1)'(AF_THRESH);
  localparam logic [PTR_WIDTH:0] ONE    = {{PTR_WIDTH{1'b0}}, 1'b1};

  logic [PTR_WIDTH:0] sync_q [SYNC_STAGES];
  logic [PTR_WIDTH:0] prev_q;
  logic [PTR_WIDTH:0] level_next;
  logic [PTR_WIDTH:0] hop;
  logic               multi_hop;
  logic               overflow;
  logic               err_set;

  function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
    logic [PTR_WIDTH:0] b;
    b[PTR_WIDTH] = g[PTR_WIDTH];
    for (int i = PTR_WIDTH - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Pure flop chain: nothing may sit between stages or metastability can escape
  always_ff @(posedge clk_w or posedge arst) begin
    if (arst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= g_rptr;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign g_rptr_sync = sync_q[SYNC_STAGES-1];

  // More than one bit set in the per-cycle difference means an illegal gray step
  always_comb begin
    level_next = b_wptr - b_rptr_sync;
    hop        = g_rptr_sync ^ prev_q;
    multi_hop  = (hop & (hop - ONE)) != '0;
    overflow   = level_next > DEPTH;
    err_set    = multi_hop | overflow;
  end

  always_ff @(posedge clk_w or posedge arst) begin
    if (arst) begin
      prev_q      <= '0;
      b_rptr_sync <= '0;
      w_level     <= '0;
      almost_full <= 1'b0;
      gray_err    <= 1'b0;
    end else begin
      prev_q      <= g_rptr_sync;
      b_rptr_sync <= gray2bin(g_rptr_sync);
      w_level     <= level_next;
      almost_full <= level_next >= AF_LVL;
      gray_err    <= err_set | (gray_err & ~clr_err);
    end
  end

endmodule
